pulse_stretch: RTL and testbench

Output-side counterpart to the push-button debouncer. It takes single-cycle event strobes, such as a debounced press pulse or a counter terminal-count tick, and produces a clean, human-visible or externally-sampled level pulse on an output pin (LED, buzzer, external strobe line). Each strobe produces exactly one high pulse of fixed length, followed by a guaranteed low gap. Strobes that arrive while a pulse or gap is in progress are queued in a saturating pending counter and are never merged.

---
 rtl/pulse_stretch_pkg.sv | 23 ++
 rtl/pulse_stretch_satcnt.sv | 49 ++++
 rtl/pulse_stretch.sv | 98 +++++++++
 tb/tb_pulse_stretch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse_stretch output driver family.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pulse_stretch_satcnt.sv
// Saturating up/down counter with sync clear and a registered overflow flag.
module pulse_stretch_satcnt #(
    parameter int unsigned MAX = 7,
    parameter int unsigned W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] MaxV = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == MaxV) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle strobes into fixed HIGH pulses separated by a guaranteed
// low gap; strobes arriving while busy are queued in a saturating counter.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned HOLD = 1000,
    parameter int unsigned GAP  = 1000,
    parameter int unsigned PEND = 7,
    parameter int unsigned PW   = clog2(PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stb,
    input  logic          clr,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          ovf
);

    localparam int unsigned MaxHg = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CW    = clog2(MaxHg + 1);
    localparam logic [CW-1:0] HoldLd = CW'(HOLD - 1);
    localparam logic [CW-1:0] GapLd  = CW'(GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_inc, q_dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_inc   = 1'b0;
        q_dec   = 1'b0;
        case (state_q)
            StIdle: begin
                // A strobe in idle starts the pulse directly and is not queued.
                if (stb) begin
                    state_d = StHigh;
                    cnt_d   = HoldLd;
                end
            end
            StHigh: begin
                q_inc = stb;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = StGap;
                    cnt_d   = GapLd;
                end
            end
            StGap: begin
                q_inc = stb;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!clr && ((pending != '0) || stb)) begin
                    // Queue after this cycle's strobe is non-empty: chain the next pulse.
                    state_d = StHigh;
                    cnt_d   = HoldLd;
                    q_dec   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pulse_stretch_satcnt #(
        .MAX (PEND),
        .W   (PW)
    ) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (q_inc),
        .dec   (q_dec),
        .cnt   (pending),
        .ovf   (ovf)
    );

    assign out  = (state_q == StHigh);
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: two instances cover HOLD=4/GAP=3/PEND=3 and
// HOLD=1/GAP=1/PEND=7.
module tb_pulse_stretch;

    logic       clk;
    logic       rst_n;
    logic       stb_a, clr_a, out_a, busy_a, ovf_a;
    logic [1:0] pend_a;
    logic       stb_b, clr_b, out_b, busy_b, ovf_b;
    logic [2:0] pend_b;

    int n_cmp;
    int n_err;

    pulse_stretch #(
        .HOLD (4),
        .GAP  (3),
        .PEND (3)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .stb     (stb_a),
        .clr     (clr_a),
        .out     (out_a),
        .busy    (busy_a),
        .pending (pend_a),
        .ovf     (ovf_a)
    );

    pulse_stretch #(
        .HOLD (1),
        .GAP  (1),
        .PEND (7)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .stb     (stb_b),
        .clr     (clr_b),
        .out     (out_b),
        .busy    (busy_b),
        .pending (pend_b),
        .ovf     (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pending count of dut_b for cycles 1..13 of the 6-strobe burst.
    logic [2:0] pend_tab [0:12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2,
                                     3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};

    initial begin
        int rises;
        int ovfs;
        int ovf_cyc;
        int high_cnt;
        int max_pend;
        int waited;
        int rise_cyc [4];
        logic prev;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        stb_a = 1'b0;
        clr_a = 1'b0;
        stb_b = 1'b0;
        clr_b = 1'b0;
        tick();
        tick();
        check("reset a", {27'd0, out_a, busy_a, pend_a, ovf_a}, 32'd0);
        check("reset b", {26'd0, out_b, busy_b, pend_b, ovf_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle a", {27'd0, out_a, busy_a, pend_a, ovf_a}, 32'd0);

        // Single event: OUT high c1..c4, gap c5..c7, idle at c8.
        stb_a = 1'b1;
        tick();
        stb_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("single c%0d", k), {27'd0, out_a, busy_a, pend_a, ovf_a},
                  {27'd0, (k <= 4) ? 1'b1 : 1'b0, (k <= 7) ? 1'b1 : 1'b0, 3'b000});
            tick();
        end

        // Asynchronous reset during the second HIGH cycle.
        stb_a = 1'b1;
        tick();
        stb_a = 1'b0;
        tick();
        check("pre-reset out", {31'd0, out_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {27'd0, out_a, busy_a, pend_a, ovf_a}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post-reset c%0d", k), {30'd0, out_a, busy_a}, 32'd0);
        end

        // Queueing: five consecutive strobes into PEND=3.
        rises = 0;
        ovfs = 0;
        ovf_cyc = -1;
        max_pend = 0;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) rise_cyc[i] = -1;
        stb_a = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 5) stb_a = 1'b0;
            if (out_a && !prev) begin
                if (rises < 4) rise_cyc[rises] = cyc;
                rises++;
            end
            prev = out_a;
            if (ovf_a) begin
                ovfs++;
                ovf_cyc = cyc;
            end
            if (int'(pend_a) > max_pend) max_pend = int'(pend_a);
            tick();
        end
        check("queue pulses", rises, 4);
        check("queue rise0", rise_cyc[0], 1);
        check("queue rise1", rise_cyc[1], 8);
        check("queue rise2", rise_cyc[2], 15);
        check("queue rise3", rise_cyc[3], 22);
        check("queue ovf count", ovfs, 1);
        check("queue ovf cycle", ovf_cyc, 5);
        check("queue max pend", max_pend, 3);
        check("queue drained", {29'd0, busy_a, pend_a}, 32'd0);

        // Full queue with a strobe on the final GAP cycle: net unchanged, no OVF.
        stb_a = 1'b1;
        tick();
        tick();
        tick();
        tick();
        stb_a = 1'b0;
        check("sim pend full", {30'd0, pend_a}, 32'd3);
        tick();
        tick();
        tick();
        check("sim last gap", {30'd0, out_a, busy_a}, 32'd1);
        stb_a = 1'b1;
        tick();
        stb_a = 1'b0;
        check("sim pend held", {30'd0, pend_a}, 32'd3);
        check("sim no ovf", {31'd0, ovf_a}, 32'd0);
        check("sim next pulse", {31'd0, out_a}, 32'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("sim clr pend", {30'd0, pend_a}, 32'd0);
        waited = 0;
        while (busy_a && waited < 20) begin
            tick();
            waited++;
        end
        check("sim idle in time", {31'd0, busy_a}, 32'd0);

        // Flush: two queued events cleared during HIGH leave exactly one pulse.
        rises = 0;
        high_cnt = 0;
        prev = 1'b0;
        stb_a = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            stb_a = (cyc <= 2);
            clr_a = (cyc == 3);
            if (cyc == 3) check("flush pend", {30'd0, pend_a}, 32'd2);
            if (cyc == 4) check("flush cleared", {30'd0, pend_a}, 32'd0);
            if (cyc == 8) check("flush idle", {31'd0, busy_a}, 32'd0);
            if (out_a && !prev) rises++;
            if (out_a) high_cnt++;
            prev = out_a;
            tick();
        end
        clr_a = 1'b0;
        check("flush pulses", rises, 1);
        check("flush high cycles", high_cnt, 4);

        // HOLD=1, GAP=1: six strobes give six alternating pulses.
        ovfs = 0;
        stb_b = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 13; cyc++) begin
            stb_b = (cyc <= 5);
            check($sformatf("edge out c%0d", cyc), {31'd0, out_b},
                  {31'd0, ((cyc % 2 == 1) && (cyc <= 11)) ? 1'b1 : 1'b0});
            check($sformatf("edge pend c%0d", cyc), {29'd0, pend_b}, {29'd0, pend_tab[cyc-1]});
            if (ovf_b) ovfs++;
            tick();
        end
        check("edge no ovf", ovfs, 0);
        check("edge idle", {31'd0, busy_b}, 32'd0);

        // Strobe on the cycle BUSY has fallen starts a pulse with no extra gap.
        stb_b = 1'b1;
        tick();
        stb_b = 1'b0;
        check("edge restart", {31'd0, out_b}, 32'd1);
        tick();
        tick();
        check("edge restart idle", {30'd0, out_b, busy_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
